cordic_wb_buffer: RTL and testbench

- Write-back end of the CORDIC pipeline: receives per-sample results (XM, YM, XR, YR, 10-bit index) from the last pipeline cell and repacks them into the 48-bit result-memory word format used by the ROM-side loader.
- Buffers results in a small FIFO so the result-memory writer can stall without losing pipeline output.
- Drives a valid/ready write port toward result RAM and reports frame completion and overflow.

---
 rtl/cordic_wb_buffer.sv | 109 ++++++++++
 tb/tb_cordic_wb_buffer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_wb_buffer.sv
// CORDIC write-back buffer: packs pipeline results into 48-bit words, queues them in a FIFO and
// drives a valid/ready result-RAM port. Define CORDIC_WB_SAT_EN to saturate residuals (adds sat_hit).
module cordic_wb_buffer #(
  parameter int DEPTH     = 8,
  parameter int AW        = 3,
  parameter int FRAME_LEN = 128
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wen_in,
  input  logic [9:0]    index_cor,
  input  logic [15:0]   XM,
  input  logic [15:0]   YM,
  input  logic [15:0]   XR,
  input  logic [15:0]   YR,
  input  logic          mem_ready,
  output logic          mem_wen,
  output logic [9:0]    mem_addr,
  output logic [47:0]   mem_d,
  output logic          frame_done,
  output logic          overflow,
`ifdef CORDIC_WB_SAT_EN
  output logic          sat_hit,
`endif
  output logic [AW:0]   level
);

  localparam int FCW = $clog2(FRAME_LEN) + 1;
  localparam logic [AW:0]  FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [FCW-1:0] FRAME_TOP = FCW'(FRAME_LEN - 1);

  logic [57:0]    fifo_mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [FCW-1:0] frame_left;
  logic [7:0]     xr_f, yr_f;
  logic [57:0]    entry;
  logic           xfer, pop, push, full, fifo_empty;

`ifdef CORDIC_WB_SAT_EN
  logic sat_now;
  assign xr_f    = (XR[15:8] != 8'd0) ? 8'hFF : XR[7:0];
  assign yr_f    = (YR[15:8] != 8'd0) ? 8'hFF : YR[7:0];
  assign sat_now = (XR[15:8] != 8'd0) || (YR[15:8] != 8'd0);
`else
  logic unused_res_hi;
  assign xr_f = XR[7:0];
  assign yr_f = YR[7:0];
  assign unused_res_hi = ^{XR[15:8], YR[15:8]};
`endif

  assign entry      = {index_cor, XM, xr_f, YM, yr_f};
  assign xfer       = mem_wen && mem_ready;
  assign fifo_empty = (level == '0);
  assign full       = (level == FULL_LVL);
  // Head moves to the output register whenever that register is free or emptying this edge.
  assign pop        = !fifo_empty && (!mem_wen || mem_ready);
  assign push       = wen_in && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_d      <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
      frame_left <= FRAME_TOP;
`ifdef CORDIC_WB_SAT_EN
      sat_hit    <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      if (wen_in && full && !pop) overflow <= 1'b1;

      if (pop) begin
        {mem_addr, mem_d} <= fifo_mem[rd_ptr];
        mem_wen           <= 1'b1;
      end else if (xfer) begin
        mem_wen <= 1'b0;
      end

      // Down-counter over accepted words; terminal count marks the last word of a frame.
      frame_done <= xfer && (frame_left == '0);
      if (xfer) begin
        if (frame_left == '0) frame_left <= FRAME_TOP;
        else                  frame_left <= frame_left - 1'b1;
      end

`ifdef CORDIC_WB_SAT_EN
      sat_hit <= push && sat_now;
`endif
    end
  end

endmodule

// File: tb/tb_cordic_wb_buffer.sv
// Self-checking bench for cordic_wb_buffer: packing vectors from a table, then hand-written
// sequences for stall, overflow, full-with-pop, framing and mid-burst reset.
module tb_cordic_wb_buffer;

  logic        clk = 1'b0;
  logic        reset, wen_in, mem_ready;
  logic [9:0]  index_cor;
  logic [15:0] XM, YM, XR, YR;
  logic        mem_wen, frame_done, overflow;
  logic [9:0]  mem_addr;
  logic [47:0] mem_d;
  logic [3:0]  level;
`ifdef CORDIC_WB_SAT_EN
  logic        sat_hit;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  cordic_wb_buffer #(.DEPTH(8), .AW(3), .FRAME_LEN(128)) dut (
    .clk(clk), .reset(reset), .wen_in(wen_in), .index_cor(index_cor),
    .XM(XM), .YM(YM), .XR(XR), .YR(YR), .mem_ready(mem_ready),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_d(mem_d),
    .frame_done(frame_done), .overflow(overflow),
`ifdef CORDIC_WB_SAT_EN
    .sat_hit(sat_hit),
`endif
    .level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] xm, ym, xr, yr;
    logic [9:0]  idx;
    logic [47:0] exp_d;
  } vec_t;

  vec_t vecs [3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_sample(input int k);
    wen_in    = 1'b1;
    XM        = 16'h1000 + k[15:0];
    YM        = 16'h2000 + k[15:0];
    XR        = {8'h00, k[7:0]};
    YR        = {8'h00, ~k[7:0]};
    index_cor = k[9:0];
  endtask

  function automatic logic [47:0] exp_word(input int k);
    logic [15:0] xm, ym;
    logic [7:0]  xr, yr;
    xm = 16'h1000 + k[15:0];
    ym = 16'h2000 + k[15:0];
    xr = k[7:0];
    yr = ~k[7:0];
    return {xm, xr, ym, yr};
  endfunction

  task automatic do_reset;
    reset     = 1'b0;
    wen_in    = 1'b0;
    mem_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    int pulses, first_t, second_t, wen_cnt;

    vecs[0] = '{16'h1234, 16'hABCD, 16'h0056, 16'h0078, 10'h2A5, 48'h1234_56AB_CD78};
`ifdef CORDIC_WB_SAT_EN
    vecs[1] = '{16'hFFFF, 16'h0000, 16'h12AB, 16'hFF01, 10'h3FF, 48'hFFFF_FF00_00FF};
`else
    vecs[1] = '{16'hFFFF, 16'h0000, 16'h12AB, 16'hFF01, 10'h3FF, 48'hFFFF_AB00_0001};
`endif
    vecs[2] = '{16'h0001, 16'h8000, 16'h0000, 16'h00FF, 10'h000, 48'h0001_0080_00FF};

    reset = 1'b1; wen_in = 1'b0; mem_ready = 1'b0;
    index_cor = '0; XM = '0; YM = '0; XR = '0; YR = '0;

    do_reset();
    check("reset_mem_wen",    mem_wen,    0);
    check("reset_mem_addr",   mem_addr,   0);
    check("reset_mem_d",      mem_d,      0);
    check("reset_frame_done", frame_done, 0);
    check("reset_overflow",   overflow,   0);
    check("reset_level",      level,      0);

    // Packing and latency from the vector table
    for (int i = 0; i < 3; i++) begin
      do_reset();
      mem_ready = 1'b1;
      XM = vecs[i].xm; YM = vecs[i].ym; XR = vecs[i].xr; YR = vecs[i].yr;
      index_cor = vecs[i].idx; wen_in = 1'b1;
      tick();
      wen_in = 1'b0;
      check("vec_wen_edge1", mem_wen, 0);
`ifdef CORDIC_WB_SAT_EN
      check("vec_sat_hit", sat_hit, (vecs[i].xr[15:8] != 0) || (vecs[i].yr[15:8] != 0));
`endif
      tick();
      check("vec_wen_edge2", mem_wen, 1);
      check("vec_mem_d",     mem_d,   vecs[i].exp_d);
      check("vec_mem_addr",  mem_addr, vecs[i].idx);
      tick();
      check("vec_wen_after", mem_wen, 0);
    end

    // Stall and hold
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      set_sample(k);
      tick();
    end
    wen_in = 1'b0;
    check("stall_level", level, 2);
    repeat (2) tick();
    check("stall_wen",  mem_wen,  1);
    check("stall_hold_d", mem_d,  exp_word(1));
    check("stall_hold_addr", mem_addr, 1);
    mem_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      check("stall_drain_wen", mem_wen, 1);
      check("stall_drain_d",   mem_d,   exp_word(k));
      tick();
    end
    check("stall_drain_done", mem_wen, 0);
    check("stall_drain_level", level, 0);

    // Overflow: ten samples against a stalled writer
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      if (k == 10) check("ovf_before_drop", overflow, 0);
      set_sample(k);
      tick();
    end
    wen_in = 1'b0;
    check("ovf_level", level, 8);
    check("ovf_flag",  overflow, 1);
    check("ovf_out_d", mem_d, exp_word(1));
    mem_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      check("ovf_drain_d", mem_d, exp_word(k));
      tick();
    end
    check("ovf_drain_done", mem_wen, 0);
    check("ovf_sticky", overflow, 1);

    // Full FIFO with a simultaneous transfer accepts the sample
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      set_sample(k);
      tick();
    end
    check("fullpop_pre_level", level, 8);
    set_sample(20);
    mem_ready = 1'b1;
    tick();
    wen_in = 1'b0;
    check("fullpop_level", level, 8);
    check("fullpop_overflow", overflow, 0);
    for (int k = 2; k <= 10; k++) begin
      check("fullpop_drain_d", mem_d, exp_word(k == 10 ? 20 : k));
      tick();
    end
    check("fullpop_drain_done", mem_wen, 0);

    // Two frames of 128 words at full rate
    do_reset();
    mem_ready = 1'b1;
    pulses = 0; first_t = -1; second_t = -1; wen_cnt = 0;
    for (int t = 1; t <= 270; t++) begin
      if (t <= 256) set_sample(t);
      else          wen_in = 1'b0;
      tick();
      if (mem_wen) wen_cnt++;
      if (frame_done) begin
        pulses++;
        if (pulses == 1) first_t = t;
        if (pulses == 2) second_t = t;
      end
    end
    check("frame_pulses",  pulses,   2);
    check("frame_first_t", first_t,  130);
    check("frame_second_t", second_t, 258);
    check("frame_words",   wen_cnt,  256);

    // Reset asserted with five words queued
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      set_sample(k);
      tick();
    end
    wen_in = 1'b0;
    check("rst_pre_level", level, 5);
    #2 reset = 1'b0;
    #1;
    check("rst_async_wen",   mem_wen, 0);
    check("rst_async_level", level,   0);
    check("rst_async_d",     mem_d,   0);
    tick();
    reset = 1'b1;
    set_sample(40);
    tick();
    wen_in = 1'b0;
    check("rst_new_edge1", mem_wen, 0);
    tick();
    check("rst_new_edge2", mem_wen, 1);
    check("rst_new_d",     mem_d,   exp_word(40));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
